// File: rtl/nds_line_capture_if.sv
// NDS LCD pin bus in, line-buffer write port out. The capture block is the
// master; the LCD source and the line-buffer RAMs sit on the slave side.
`timescale 1ns/1ps
interface nds_line_capture_if;
    logic        nds_pix_clk;
    logic        nds_hsync;
    logic        nds_vsync;
    logic [17:0] nds_data;

    logic        wr_en_a;
    logic        wr_en_b;
    logic [7:0]  wr_addr;
    logic [17:0] wr_data;
    logic        wr_bank;
    logic [7:0]  line_num;
    logic        line_done;
    logic        frame_start;
    logic        short_line;
    logic        in_sync;

    modport master (
        input  nds_pix_clk, nds_hsync, nds_vsync, nds_data,
        output wr_en_a, wr_en_b, wr_addr, wr_data, wr_bank,
               line_num, line_done, frame_start, short_line, in_sync
    );

    modport slave (
        output nds_pix_clk, nds_hsync, nds_vsync, nds_data,
        input  wr_en_a, wr_en_b, wr_addr, wr_data, wr_bank,
               line_num, line_done, frame_start, short_line, in_sync
    );
endinterface

// File: rtl/nds_line_capture.sv
// Oversampled NDS LCD capture: rising-edge data goes to screen A, falling-edge data to screen B.
// Strobes land 1 clk after the synchronised edge is seen; no backpressure, the LCD cannot be stalled.
`timescale 1ns/1ps
module nds_line_capture #(
    parameter int H_PORCH      = 4,
    parameter int ACTIVE_PIX   = 256,
    parameter int ACTIVE_LINES = 192,
    parameter int DATA_TAP     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    nds_line_capture_if.master   bus
);

    localparam logic [3:0] PORCH_LAST = 4'(H_PORCH - 1);
    localparam logic [8:0] PIX_LAST   = 9'(ACTIVE_PIX - 1);
    localparam logic [7:0] LINE_LAST  = 8'(ACTIVE_LINES - 1);

    typedef enum logic [2:0] {
        WAIT_V,
        WAIT_H,
        PORCH,
        ACTIVE,
        LINE_END
    } state_t;

    state_t state_q, state_d;

    logic [2:0]               pclk_sync_q;
    logic [2:0]               hs_sync_q;
    logic [2:0]               vs_sync_q;
    // Data chain stops at the tap stage; later copies would have no reader.
    logic [DATA_TAP:0][17:0]  data_sync_q;

    logic [3:0]  porch_cnt_q, porch_cnt_d;
    logic [8:0]  pix_cnt_q,   pix_cnt_d;
    logic        a_done_q,    a_done_d;
    logic [7:0]  line_num_q,  line_num_d;
    logic        short_q,     short_d;
    logic        in_sync_q,   in_sync_d;
    logic        wr_en_a_q,   wr_en_a_d;
    logic        wr_en_b_q,   wr_en_b_d;
    logic [7:0]  wr_addr_q,   wr_addr_d;
    logic [17:0] wr_data_q,   wr_data_d;
    logic        line_done_q, line_done_d;
    logic        frame_start_q, frame_start_d;

    logic        pclk_rise, pclk_fall, h_fall, v_fall;
    logic [17:0] tap_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sync_q <= '1;
            hs_sync_q   <= '1;
            vs_sync_q   <= '1;
            data_sync_q <= '1;
        end else begin
            pclk_sync_q    <= {pclk_sync_q[1:0], bus.nds_pix_clk};
            hs_sync_q      <= {hs_sync_q[1:0],   bus.nds_hsync};
            vs_sync_q      <= {vs_sync_q[1:0],   bus.nds_vsync};
            data_sync_q[0] <= bus.nds_data;
            for (int i = 1; i <= DATA_TAP; i++) begin
                data_sync_q[i] <= data_sync_q[i-1];
            end
        end
    end

    assign pclk_rise =  pclk_sync_q[1] & ~pclk_sync_q[2];
    assign pclk_fall = ~pclk_sync_q[1] &  pclk_sync_q[2];
    assign h_fall    = ~hs_sync_q[1]   &  hs_sync_q[2];
    assign v_fall    = ~vs_sync_q[1]   &  vs_sync_q[2];
    assign tap_dat   = data_sync_q[DATA_TAP];

    always_comb begin
        state_d       = state_q;
        porch_cnt_d   = porch_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        a_done_d      = a_done_q;
        line_num_d    = line_num_q;
        short_d       = short_q;
        in_sync_d     = in_sync_q;
        wr_en_a_d     = 1'b0;
        wr_en_b_d     = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        line_done_d   = 1'b0;
        frame_start_d = 1'b0;

        if (v_fall) begin
            // A vsync outside WAIT_V means the previous frame was cut short.
            frame_start_d = 1'b1;
            line_num_d    = '0;
            short_d       = 1'b0;
            if (state_q != WAIT_V) begin
                in_sync_d = 1'b0;
            end
            state_d = WAIT_H;
        end else begin
            case (state_q)
                WAIT_V: begin
                end
                WAIT_H: begin
                    if (h_fall) begin
                        porch_cnt_d = '0;
                        state_d     = PORCH;
                    end
                end
                PORCH, ACTIVE: begin
                    if (h_fall) begin
                        short_d     = 1'b1;
                        porch_cnt_d = '0;
                        if (line_num_q == LINE_LAST) begin
                            line_num_d = '0;
                            in_sync_d  = 1'b0;
                            state_d    = WAIT_V;
                        end else begin
                            line_num_d = line_num_q + 8'd1;
                            state_d    = PORCH;
                        end
                    end else if (state_q == PORCH) begin
                        if (pclk_rise) begin
                            if (porch_cnt_q == PORCH_LAST) begin
                                pix_cnt_d = '0;
                                a_done_d  = 1'b0;
                                state_d   = ACTIVE;
                            end else begin
                                porch_cnt_d = porch_cnt_q + 4'd1;
                            end
                        end
                    end else begin
                        // The fall right after the last porch rise is that porch
                        // pixel's B half; a B write needs its A partner first.
                        if (pclk_rise) begin
                            wr_en_a_d = 1'b1;
                            wr_addr_d = pix_cnt_q[7:0];
                            wr_data_d = tap_dat;
                            a_done_d  = 1'b1;
                        end else if (pclk_fall && a_done_q) begin
                            wr_en_b_d = 1'b1;
                            wr_addr_d = pix_cnt_q[7:0];
                            wr_data_d = tap_dat;
                            a_done_d  = 1'b0;
                            pix_cnt_d = pix_cnt_q + 9'd1;
                            if (pix_cnt_q == PIX_LAST) begin
                                line_done_d = 1'b1;
                                state_d     = LINE_END;
                            end
                        end
                    end
                end
                LINE_END: begin
                    if (line_num_q == LINE_LAST) begin
                        line_num_d = '0;
                        in_sync_d  = 1'b1;
                        state_d    = WAIT_V;
                    end else begin
                        line_num_d = line_num_q + 8'd1;
                        state_d    = WAIT_H;
                    end
                end
                default: state_d = WAIT_V;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_V;
            porch_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            a_done_q      <= 1'b0;
            line_num_q    <= '0;
            short_q       <= 1'b0;
            in_sync_q     <= 1'b0;
            wr_en_a_q     <= 1'b0;
            wr_en_b_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            line_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            porch_cnt_q   <= porch_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            a_done_q      <= a_done_d;
            line_num_q    <= line_num_d;
            short_q       <= short_d;
            in_sync_q     <= in_sync_d;
            wr_en_a_q     <= wr_en_a_d;
            wr_en_b_q     <= wr_en_b_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            line_done_q   <= line_done_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.wr_en_a     = wr_en_a_q;
    assign bus.wr_en_b     = wr_en_b_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_bank     = line_num_q[0];
    assign bus.line_num    = line_num_q;
    assign bus.line_done   = line_done_q;
    assign bus.frame_start = frame_start_q;
    assign bus.short_line  = short_q;
    assign bus.in_sync     = in_sync_q;

endmodule

// File: doc/nds_line_capture.md
Name: nds_line_capture

Overview:
- Front-end capture stage that feeds the dual-display line buffers.
- Oversamples the NDS LCD bus (pixel clock, hsync, vsync, 18-bit data) in the single fast system clock domain, so no logic is clocked by nds_pix_clk.
- Data sampled at a pixel-clock rising edge is top-screen (A) data; data sampled at a falling edge is bottom-screen (B) data.
- Emits write strobes, addresses, a ping-pong bank bit and line/frame events toward the line-buffer RAMs.

Parameters:
- H_PORCH, 4: pixel-clock rising edges discarded after the hsync falling edge before pixel 0.
- ACTIVE_PIX, 256: pixels written per line per screen.
- ACTIVE_LINES, 192: lines per frame.
- DATA_TAP, 1: synchronizer stage (0..2) whose nds_data copy is written. Aligns data with the detected edge.

Ports:
- clk  in  1  system clock, 54 MHz, at least 4x nds_pix_clk.
- rst  in  1  synchronous active-high reset.
- nds_pix_clk  in  1  asynchronous NDS pixel clock.
- nds_hsync  in  1  asynchronous, active low.
- nds_vsync  in  1  asynchronous, active low.
- nds_data  in  18  asynchronous pixel data: R[5:0], G[11:6], B[17:12].
- wr_en_a  out  1  one-cycle write strobe, screen A buffer.
- wr_en_b  out  1  one-cycle write strobe, screen B buffer.
- wr_addr  out  8  pixel index 0..255.
- wr_data  out  18  pixel data.
- wr_bank  out  1  ping-pong buffer select, equal to line_num[0].
- line_num  out  8  current active line, 0..191.
- line_done  out  1  one-cycle pulse after pixel 255 of a line is written.
- frame_start  out  1  one-cycle pulse on the vsync falling edge.
- short_line  out  1  sticky error flag; cleared by rst or frame_start.
- in_sync  out  1  high once a complete frame of ACTIVE_LINES good lines has been captured.

Behaviour:
- Synchronizers:
  - Three-flop chains on nds_pix_clk, nds_hsync and nds_vsync; edges are detected between stages 1 and 2.
  - nds_data passes through a parallel 3-deep register chain; the DATA_TAP stage supplies wr_data.
- Edge definitions:
  - pclk_rise = s1 & ~s2; pclk_fall = ~s1 & s2.
  - h_fall and v_fall are defined the same way on their chains.
- Reset: every output is 0. State = WAIT_V. All counters are 0. All sync chains load 1s (idle level).
- States:
  - WAIT_V: wait for v_fall. On v_fall: assert frame_start, line_num <= 0, clear short_line, go to WAIT_H.
  - WAIT_H: on h_fall: porch_cnt <= 0, go to PORCH.
  - PORCH: each pclk_rise increments porch_cnt. When porch_cnt == H_PORCH-1 on a pclk_rise: pix_cnt <= 0, go to ACTIVE. That edge's data is discarded.
  - ACTIVE:
    - pclk_rise: wr_en_a = 1, wr_addr = pix_cnt.
    - pclk_fall: wr_en_b = 1, wr_addr = pix_cnt, then pix_cnt++.
    - After the B write at pix_cnt == ACTIVE_PIX-1: pulse line_done, go to LINE_END.
  - LINE_END (one cycle): line_num++.
    - If the new line_num == ACTIVE_LINES: in_sync <= 1, go to WAIT_V.
    - Otherwise go to WAIT_H.
- Strobes and outputs:
  - Strobes are registered, so they appear 1 clk after the detected edge; wr_addr, wr_data and wr_bank are valid in the same cycle as the strobe.
  - wr_en_a and wr_en_b are never high together.
  - Exactly one strobe per pixel-clock edge in ACTIVE.
- Boundary conditions:
  - h_fall during PORCH or ACTIVE (short line): set short_line, line_num++ without a line_done pulse, restart PORCH for the new line. Pixels already written remain.
  - v_fall in any state (including mid-line) takes priority over every other event. Abort the line, pulse frame_start, line_num <= 0, go to WAIT_H.
  - A v_fall arriving before ACTIVE_LINES lines completed clears in_sync.
  - h_fall in WAIT_V is ignored.
  - Surplus pixel edges after the last pixel of a line (LINE_END or WAIT_H) are ignored, with no strobes.
  - h_fall and pclk_rise in the same cycle in WAIT_H: the h_fall is taken; that pclk_rise does not count toward the porch.
  - rst mid-line: outputs drop to 0 on the next clk. Capture resumes only after the next v_fall.
  - Counter widths: porch_cnt 4 bits, pix_cnt 9 bits, line_num 8 bits. line_num never exceeds ACTIVE_LINES-1 while visible on the port.

Test Plan:
- Nominal frame. Stimulus: pix_clk 4.2 MHz, 192 lines of 256+H_PORCH+60 pixels, data = {line,pixel} pattern. Response: 49152 wr_en_a and 49152 wr_en_b strobes, addr 0..255 per line, 192 line_done pulses, wr_bank toggles every line, in_sync = 1 at frame end.
- A/B split. Stimulus: data = 18'h0003F before each rising edge and 18'h00FC0 before each falling edge. Response: every wr_en_a carries 0003F and every wr_en_b carries 00FC0.
- Porch. Stimulus: first 4 edges of each line carry 18'h3FFFF. Response: no 3FFFF value is written; the first A write is at addr 0.
- Short line. Stimulus: hsync falls after 100 pixels on line 10. Response: short_line = 1, no line_done for line 10, line_num = 11, the next line captures normally.
- Mid-line vsync. Stimulus: vsync falls during pixel 50 of line 30. Response: frame_start pulse, line_num = 0, in_sync = 0, short_line cleared, no further strobes until PORCH completes.
- Reset mid-ACTIVE. Stimulus: rst asserted for 2 clk. Response: all outputs 0; no strobes until the next v_fall plus H_PORCH.
